base3_to_base2: RTL



---
 rtl/base3_pkg.sv | 19 +
 rtl/base3_mac_step.sv | 23 ++
 rtl/base3_to_base2.sv | 128 ++++++++++++
 3 files changed

// File: rtl/base3_pkg.sv
// Shared definitions for the base-3 <-> base-2 steganography converters.
package base3_pkg;

  localparam int unsigned N_TRITS_DEF = 16;
  localparam int unsigned OUT_W_DEF   = 16;
  // Smallest width with 2^ACC_W > 3^16 - 1, so the accumulator never wraps.
  localparam int unsigned ACC_W_DEF   = 26;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_INV = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/base3_mac_step.sv
// One Horner step: acc_out = acc_in*3 + trit, using shift-add only.
// An invalid trit (11) is flagged and contributes 0.
module base3_mac_step
  import base3_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [1:0]       trit,
  output logic [ACC_W-1:0] acc_out,
  output logic             inv
);

  logic [1:0] trit_eff;

  // Mask the invalid code, then accumulate acc*2 + acc + trit.
  always_comb begin
    inv      = (trit == TRIT_INV);
    trit_eff = inv ? TRIT_0 : trit;
    acc_out  = (acc_in << 1) + acc_in + ACC_W'(trit_eff);
  end

endmodule

// File: rtl/base3_to_base2.sv
// Sequential base-3 to binary converter: one trit per clock, MSB trit
// first, Horner accumulation with saturation and invalid-trit reporting.
module base3_to_base2
  import base3_pkg::*;
#(
  parameter int unsigned N_TRITS = N_TRITS_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*N_TRITS-1:0]   base3_no,
  input  logic                   en,
  output logic [OUT_W-1:0]       base2_no,
  output logic                   done,
  output logic                   busy,
  output logic                   err,
  output logic                   ovf
);

  localparam int unsigned SH_W  = 2 * N_TRITS;
  localparam int unsigned CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_i_q, err_i_d;
  logic [OUT_W-1:0]   base2_no_d;
  logic               done_d, busy_d, err_d, ovf_d;

  logic [1:0]         trit_c;
  logic [ACC_W-1:0]   acc_step_c;
  logic               inv_c;
  logic               err_fin_c;
  logic               ovf_fin_c;

  // Current trit, walking from the most significant position downward.
  assign trit_c = sh_q[{cnt_q, 1'b0} +: 2];

  base3_mac_step #(
    .ACC_W (ACC_W)
  ) u_mac_step (
    .acc_in  (acc_q),
    .trit    (trit_c),
    .acc_out (acc_step_c),
    .inv     (inv_c)
  );

  // State and datapath registers; reset abandons any conversion silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      err_i_q  <= 1'b0;
      base2_no <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_i_q  <= err_i_d;
      base2_no <= base2_no_d;
      done     <= done_d;
      busy     <= busy_d;
      err      <= err_d;
      ovf      <= ovf_d;
    end
  end

  // Next-state and output logic; results and flags hold between done pulses.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_i_d    = err_i_q;
    base2_no_d = base2_no;
    done_d     = 1'b0;
    busy_d     = busy;
    err_d      = err;
    ovf_d      = ovf;
    err_fin_c  = err_i_q | inv_c;
    ovf_fin_c  = (acc_step_c[ACC_W-1:OUT_W] != '0) && !err_fin_c;

    case (state_q)
      IDLE: begin
        if (en) begin
          sh_d    = base3_no;
          acc_d   = '0;
          cnt_d   = CNT_W'(N_TRITS - 1);
          err_i_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (inv_c) begin
          err_i_d = 1'b1;
        end
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          err_d   = err_fin_c;
          ovf_d   = ovf_fin_c;
          if (err_fin_c) begin
            base2_no_d = '0;
          end else if (ovf_fin_c) begin
            base2_no_d = '1;
          end else begin
            base2_no_d = acc_step_c[OUT_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
